// File: rtl/t05_find_least.sv
// Scans a 256-entry histogram in SRAM and reports the two characters with the
// smallest nonzero counts, their sum, and the number of nonzero entries.
module t05_find_least #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        en_state,
  input  logic [DATA_W-1:0] sram_in,
  input  logic              sram_valid,
  output logic              rd_en,
  output logic [7:0]        hist_addr,
  output logic [7:0]        least1_char,
  output logic [DATA_W-1:0] least1_cnt,
  output logic [7:0]        least2_char,
  output logic [DATA_W-1:0] least2_cnt,
  output logic [DATA_W:0]   sum,
  output logic [8:0]        nonzero,
  output logic              done,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, CMP, DONE} state_t;

  state_t              state;
  logic [7:0]          addr;
  logic [DATA_W-1:0]   cap_cnt_p0;
  logic                valid1;
  logic                valid2;
  logic                active;

  logic [7:0]          n1_char;
  logic [DATA_W-1:0]   n1_cnt;
  logic                n1_vld;
  logic [7:0]          n2_char;
  logic [DATA_W-1:0]   n2_cnt;
  logic                n2_vld;

  assign active = (en_state == 4'd2);

  // Zero-extended add; an empty slot contributes nothing.
  function automatic logic [DATA_W:0] add_cnt(input logic [DATA_W-1:0] a,
                                               input logic              a_vld,
                                               input logic [DATA_W-1:0] b,
                                               input logic              b_vld);
    logic [DATA_W:0] ea;
    logic [DATA_W:0] eb;
    ea = a_vld ? {1'b0, a} : '0;
    eb = b_vld ? {1'b0, b} : '0;
    return ea + eb;
  endfunction

  // Candidate slot contents if the captured count is merged this cycle.
  always_comb begin
    n1_char = least1_char;
    n1_cnt  = least1_cnt;
    n1_vld  = valid1;
    n2_char = least2_char;
    n2_cnt  = least2_cnt;
    n2_vld  = valid2;
    if (cap_cnt_p0 != '0) begin
      if (!valid1 || (cap_cnt_p0 < least1_cnt)) begin
        n2_char = least1_char;
        n2_cnt  = least1_cnt;
        n2_vld  = valid1;
        n1_char = addr;
        n1_cnt  = cap_cnt_p0;
        n1_vld  = 1'b1;
      end else if (!valid2 || (cap_cnt_p0 < least2_cnt)) begin
        n2_char = addr;
        n2_cnt  = cap_cnt_p0;
        n2_vld  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      cap_cnt_p0  <= '0;
      valid1      <= 1'b0;
      valid2      <= 1'b0;
      least1_char <= '0;
      least1_cnt  <= '0;
      least2_char <= '0;
      least2_cnt  <= '0;
      sum         <= '0;
      nonzero     <= '0;
      rd_en       <= 1'b0;
      hist_addr   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (active) begin
            state       <= REQ;
            addr        <= '0;
            cap_cnt_p0  <= '0;
            valid1      <= 1'b0;
            valid2      <= 1'b0;
            least1_char <= '0;
            least1_cnt  <= '0;
            least2_char <= '0;
            least2_cnt  <= '0;
            sum         <= '0;
            nonzero     <= '0;
            rd_en       <= 1'b1;
            hist_addr   <= '0;
            busy        <= 1'b1;
          end
        end
        REQ: begin
          if (!active) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!active) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sram_valid) begin
            cap_cnt_p0 <= sram_in;
            state      <= CMP;
          end
        end
        // ---- merge stage: captured count folded into the two slots ----
        CMP: begin
          if (!active) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            least1_char <= n1_char;
            least1_cnt  <= n1_cnt;
            valid1      <= n1_vld;
            least2_char <= n2_char;
            least2_cnt  <= n2_cnt;
            valid2      <= n2_vld;
            sum         <= add_cnt(n1_cnt, n1_vld, n2_cnt, n2_vld);
            if (cap_cnt_p0 != '0) begin
              nonzero <= nonzero + 9'd1;
            end
            if (addr == 8'hFF) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              addr      <= addr + 8'd1;
              hist_addr <= addr + 8'd1;
              rd_en     <= 1'b1;
              state     <= REQ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t05_find_least.sv
// Scoreboard bench for t05_find_least: an SRAM responder model, a reference
// two-smallest search over the histogram array, and a decoupled done monitor.
module tb_t05_find_least;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  en_state = 4'd0;
  logic [31:0] sram_in = 32'd0;
  logic        sram_valid = 1'b0;
  logic        rd_en;
  logic [7:0]  hist_addr;
  logic [7:0]  least1_char;
  logic [31:0] least1_cnt;
  logic [7:0]  least2_char;
  logic [31:0] least2_cnt;
  logic [32:0] sum;
  logic [8:0]  nonzero;
  logic        done;
  logic        busy;

  t05_find_least #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .en_state(en_state), .sram_in(sram_in),
    .sram_valid(sram_valid), .rd_en(rd_en), .hist_addr(hist_addr),
    .least1_char(least1_char), .least1_cnt(least1_cnt),
    .least2_char(least2_char), .least2_cnt(least2_cnt),
    .sum(sum), .nonzero(nonzero), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  c1;
    logic [31:0] n1;
    logic [7:0]  c2;
    logic [31:0] n2;
    logic [32:0] sum;
    logic [8:0]  nz;
    int          done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] hist[256];
  int          rsp_delay = 1;
  bit          noise = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // SRAM model: returns hist[addr] rsp_delay cycles after rd_en; optional
  // junk strobes outside the wait window.
  int pend = 0;
  int paddr = 0;
  always begin
    @(negedge clk);
    if (rd_en) begin
      pend  = rsp_delay;
      paddr = int'(hist_addr);
    end
    @(posedge clk);
    #1;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        sram_valid = 1'b1;
        sram_in    = hist[paddr];
      end else begin
        sram_valid = 1'b0;
        sram_in    = $urandom;
      end
    end else begin
      sram_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      sram_in    = $urandom;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: two smallest nonzero counts over hist[0..last], lower address on ties.
  function automatic exp_t model(input int last);
    exp_t e;
    int b1;
    int b2;
    b1 = -1;
    b2 = -1;
    e.nz = '0;
    for (int i = 0; i <= last; i++) begin
      if (hist[i] != 0) begin
        e.nz = e.nz + 9'd1;
        if (b1 < 0 || hist[i] < hist[b1]) b1 = i;
      end
    end
    for (int i = 0; i <= last; i++) begin
      if (hist[i] != 0 && i != b1) begin
        if (b2 < 0 || hist[i] < hist[b2]) b2 = i;
      end
    end
    if (b1 < 0) begin e.c1 = 8'd0; e.n1 = 32'd0; end
    else begin e.c1 = 8'(b1); e.n1 = hist[b1]; end
    if (b2 < 0) begin e.c2 = 8'd0; e.n2 = 32'd0; end
    else begin e.c2 = 8'(b2); e.n2 = hist[b2]; end
    e.sum = {1'b0, e.n1} + {1'b0, e.n2};
    e.done_cyc = 0;
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    int start_cyc = 0;
    int exp_addr = 0;
    int addr_bad = 0;
    int n_rd = 0;
    forever begin
      @(negedge clk);
      if (!rst && !busy && en_state == 4'd2) begin
        start_cyc = cyc;
        exp_addr  = 0;
        addr_bad  = 0;
        n_rd      = 0;
      end
      if (rd_en) begin
        if (hist_addr != 8'(exp_addr)) addr_bad++;
        exp_addr++;
        n_rd++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("least1_char", 64'(least1_char), 64'(e.c1));
          chk("least1_cnt",  64'(least1_cnt),  64'(e.n1));
          chk("least2_char", 64'(least2_char), 64'(e.c2));
          chk("least2_cnt",  64'(least2_cnt),  64'(e.n2));
          chk("sum",         64'(sum),         64'(e.sum));
          chk("nonzero",     64'(nonzero),     64'(e.nz));
          chk("done_cycle",  64'(cyc - start_cyc), 64'(e.done_cyc));
          chk("addr_seq",    64'(addr_bad), 64'd0);
          chk("rd_count",    64'(n_rd), 64'd256);
        end
      end
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 256; i++) hist[i] = 32'd0;
  endtask

  task automatic rand_hist();
    int r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      hist[i] = 32'd0;
      else if (r < 8) hist[i] = 32'($urandom_range(1, 20));
      else            hist[i] = $urandom;
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_rd_en"}, 64'(rd_en), 64'd0);
    chk({p, "_hist_addr"}, 64'(hist_addr), 64'd0);
    chk({p, "_l1c"}, 64'(least1_char), 64'd0);
    chk({p, "_l1n"}, 64'(least1_cnt), 64'd0);
    chk({p, "_l2c"}, 64'(least2_char), 64'd0);
    chk({p, "_l2n"}, 64'(least2_cnt), 64'd0);
    chk({p, "_sum"}, 64'(sum), 64'd0);
    chk({p, "_nz"}, 64'(nonzero), 64'd0);
    chk({p, "_done"}, 64'(done), 64'd0);
    chk({p, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run_scan(input int dly, input bit nse);
    exp_t e;
    bit   seen;
    e = model(255);
    e.done_cyc = 1 + 256 * (dly + 2);
    exp_q.push_back(e);
    rsp_delay = dly;
    noise     = nse;
    @(posedge clk); #1;
    en_state = 4'd2;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    en_state = 4'd0;
    chk("done_seen", 64'(done), 64'd1);
    @(posedge clk); #1;
    chk("done_pulse_len", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("hold_l1", 64'(least1_cnt), 64'(e.n1));
    chk("hold_l2c", 64'(least2_char), 64'(e.c2));
    repeat (2) @(posedge clk);
  endtask

  task automatic start_and_reach(input logic [7:0] a, output bit found);
    rsp_delay = 1;
    noise     = 1'b0;
    @(posedge clk); #1;
    en_state = 4'd2;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk); #1;
      if (rd_en && hist_addr == a) found = 1'b1;
    end
  endtask

  initial begin
    exp_t e;
    bit   found;
    int   nd;
    fork monitor(); join_none
    clear_hist();

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    en_state = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("no_start_en3", 64'(busy), 64'd0);
    en_state = 4'd0;

    hist[8'h61] = 32'd5;
    hist[8'h62] = 32'd3;
    run_scan(1, 1'b0);

    clear_hist();
    hist[8'h41] = 32'd7;
    hist[8'h42] = 32'd7;
    hist[8'h43] = 32'd7;
    run_scan(1, 1'b1);

    clear_hist();
    hist[8'hFF] = 32'hFFFFFFFF;
    run_scan(1, 1'b0);

    clear_hist();
    hist[8'h10] = 32'hFFFFFFFF;
    hist[8'h20] = 32'hFFFFFFFE;
    run_scan(1, 1'b1);

    clear_hist();
    hist[8'h61] = 32'd5;
    hist[8'h62] = 32'd3;
    run_scan(4, 1'b1);

    clear_hist();
    run_scan(1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      rand_hist();
      run_scan(1 + (k % 2) * $urandom_range(1, 3), 1'b1);
    end

    // Abort by dropping en_state while address 100 is being requested.
    rand_hist();
    start_and_reach(8'd100, found);
    chk("abort_reach", 64'(found), 64'd1);
    en_state = 4'd0;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rd_en", 64'(rd_en), 64'd0);
    e = model(99);
    chk("abort_l1c", 64'(least1_char), 64'(e.c1));
    chk("abort_l1n", 64'(least1_cnt), 64'(e.n1));
    chk("abort_l2c", 64'(least2_char), 64'(e.c2));
    chk("abort_l2n", 64'(least2_cnt), 64'(e.n2));
    chk("abort_sum", 64'(sum), 64'(e.sum));
    chk("abort_nz", 64'(nonzero), 64'(e.nz));
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);

    // Reset in the middle of a scan.
    start_and_reach(8'd50, found);
    chk("rst_reach", 64'(found), 64'd1);
    rst = 1'b1;
    en_state = 4'd0;
    @(posedge clk); #1;
    chk_zero("midrst");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    clear_hist();
    hist[8'h61] = 32'd5;
    hist[8'h62] = 32'd3;
    run_scan(1, 1'b0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/t05_find_least.md
T05_FIND_LEAST -- requirements
Module: t05_find_least

Interface
REQ-001 The module SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- en_state  in  4  controller state; the block is active only while en_state == 4'd2.
- sram_in  in  32  histogram count returned by SRAM.
- sram_valid  in  1  SRAM read-data-valid strobe.
- rd_en  out  1  SRAM read request, one-cycle pulse.
- hist_addr  out  8  SRAM histogram address.
- least1_char  out  8  character with the smallest nonzero count.
- least1_cnt  out  32  count of least1_char.
- least2_char  out  8  character with the second-smallest nonzero count.
- least2_cnt  out  32  count of least2_char.
- sum  out  33  least1_cnt + least2_cnt.
- nonzero  out  9  number of histogram entries with a nonzero count (0..256).
- done  out  1  one-cycle pulse when a scan is complete.
- busy  out  1  high while a scan is in progress.

Function
REQ-002 State machine SHALL have exactly five states: IDLE, REQ, WAIT, CMP, DONE.
REQ-003 IDLE -> REQ SHALL occur when en_state == 2, with the address counter cleared to 0, the valid flags, both counts, both characters and nonzero cleared.
REQ-004 REQ SHALL drive rd_en = 1 and hist_addr = address counter for one cycle, then go to WAIT.
REQ-005 WAIT SHALL hold until sram_valid = 1, capture sram_in, then go to CMP.
REQ-006 sram_valid SHALL be ignored in all states other than WAIT.
REQ-007 CMP, for a captured count c at address a:
- c == 0: no change.
- Else, if !valid1 or c < least1_cnt: slot 2 <= slot 1 (data and valid), slot 1 <= (a, c), valid1 <= 1.
- Else, if !valid2 or c < least2_cnt: slot 2 <= (a, c), valid2 <= 1.
- nonzero increments on every c != 0.
REQ-008 Comparisons SHALL be strict less-than. Because the scan runs in ascending address order, the lower address wins a tie.
REQ-009 After CMP, if the address is 255 the state SHALL go to DONE. Otherwise the address SHALL increment and the state SHALL go to REQ. The address counter SHALL never wrap within a scan.
REQ-010 DONE SHALL assert done for exactly one cycle, then return to IDLE. A new scan SHALL NOT start until IDLE sees en_state == 2 again, so a held en_state == 2 restarts one cycle after DONE.
REQ-011 sum SHALL be computed as the 33-bit zero-extended sum, with no overflow loss. A slot with valid = 0 contributes 0.
REQ-012 Result outputs SHALL update only in CMP and SHALL hold their values from DONE until the next IDLE -> REQ transition.
REQ-013 busy SHALL be 1 in REQ, WAIT, CMP and DONE, and 0 in IDLE.
REQ-014 Timing with sram_valid arriving in the first WAIT cycle (start cycle = the IDLE cycle sampling en_state == 2, counted as cycle 0):
- REQ for entry k SHALL occur at cycle 1+3k.
- done SHALL be high at cycle 769.
REQ-015 If en_state != 2 in any non-IDLE state, the next state SHALL be IDLE. done SHALL NOT pulse, and result outputs SHALL keep their partial values.
REQ-016 If fewer than two entries are nonzero, an unfilled slot SHALL read char 0 and cnt 0. nonzero reports 0 or 1 in that case.
REQ-017 hist_addr SHALL hold its last value outside REQ. rd_en SHALL be 0 outside REQ.

Reset
REQ-018 On rst sampled high at a clock edge, the block SHALL go to IDLE and all outputs, the address counter, the valid flags and captured data SHALL be 0. Reset SHALL take priority over every other condition, including mid-scan.
REQ-019 No output SHALL change asynchronously to clk.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Histogram all zero except 'a'=5 and 'b'=3, sram_valid one cycle after rd_en:
  - least1 = 'b'/3, least2 = 'a'/5, sum = 8, nonzero = 2.
  - done at cycle 769.
- Entries 0x41=7, 0x42=7, 0x43=7 (tie): least1 = 0x41/7, least2 = 0x42/7, nonzero = 3.
- Only entry 0xFF = 32'hFFFFFFFF: least1 = 0xFF/FFFFFFFF, least2 = 0/0, sum = 33'h0FFFFFFFF, nonzero = 1.
- Entries 0x10 = 0xFFFFFFFF and 0x20 = 0xFFFFFFFE: least1 = 0x20, sum = 33'h1FFFFFFFD.
- sram_valid delayed 4 cycles for every read: results unchanged, done at cycle 256*6 + 1.
- en_state dropped to 0 at address 100: IDLE next cycle, no done pulse. rst at address 50: all outputs 0 next cycle.
